// File: rtl/yarp_pkg.sv
// Shared YARP types: access sizes, memory-arbiter state and owner encodings,
// and the alignment rule used when a request is captured.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE_ACCESS      = 2'b00,
    HALF_WORD_ACCESS = 2'b01,
    RESERVED         = 2'b10,
    WORD_ACCESS      = 2'b11
  } access_byte_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_t;

  // True when an access of this size may not start at this byte offset.
  function automatic logic is_misaligned(input access_byte_t size, input logic [1:0] addr_lo);
    case (size)
      WORD_ACCESS:      return addr_lo != 2'b00;
      HALF_WORD_ACCESS: return addr_lo[0];
      RESERVED:         return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/yarp_arb_pick.sv
// Grant-owner selection for the memory arbiter.
// YARP_ARB_RR_EN: on a tie the port not granted last wins; otherwise dm > if.
module yarp_arb_pick
  import yarp_pkg::*;
(
  input  logic       i_if_req,
  input  logic       i_dm_req,
  input  arb_owner_t i_last_owner,
  output arb_owner_t o_owner
);

`ifdef YARP_ARB_RR_EN
  // Round-robin on a tie, single requester always wins
  always_comb begin
    o_owner = OWN_IF;
    if (i_dm_req && i_if_req)
      o_owner = (i_last_owner == OWN_DM) ? OWN_IF : OWN_DM;
    else if (i_dm_req)
      o_owner = OWN_DM;
  end
`else
  // Last owner has no say in fixed priority
  logic w_unused_last;
  assign w_unused_last = i_last_owner;

  // Data port always beats fetch
  always_comb begin
    o_owner = i_dm_req ? OWN_DM : OWN_IF;
  end
`endif

endmodule

// File: rtl/yarp_mem_arb.sv
// Fetch / load-store arbiter onto one external memory port. One request in
// flight; misaligned accesses are answered locally with err and rdata=0.
// Build option YARP_ARB_RR_EN selects round-robin tie breaking in yarp_arb_pick.
module yarp_mem_arb
  import yarp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_err_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  access_byte_t      dm_size_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output access_byte_t      mem_size_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_t        r_state, w_state_nxt;
  arb_owner_t        r_owner, w_pick;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  access_byte_t      r_size;
  logic [DATA_W-1:0] r_wdata;
  logic              r_if_gnt, r_dm_gnt, r_err_pend;
  logic              r_if_rvalid, r_dm_rvalid, r_if_err, r_dm_err;
  logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;

  logic              w_capture, w_cap_err, w_resp;
  logic              w_cap_we;
  logic [ADDR_W-1:0] w_cap_addr;
  access_byte_t      w_cap_size;
  logic [DATA_W-1:0] w_cap_wdata;

  // The current owner doubles as the last-grant history for round-robin.
  yarp_arb_pick u_pick (
    .i_if_req     (if_req_i),
    .i_dm_req     (dm_req_i),
    .i_last_owner (r_owner),
    .o_owner      (w_pick)
  );

  // Payload of the port being picked; fetch is always a word read
  always_comb begin
    w_cap_we    = 1'b0;
    w_cap_addr  = if_addr_i;
    w_cap_size  = WORD_ACCESS;
    w_cap_wdata = '0;
    if (w_pick == OWN_DM) begin
      w_cap_we    = dm_we_i;
      w_cap_addr  = dm_addr_i;
      w_cap_size  = dm_size_i;
      w_cap_wdata = dm_wdata_i;
    end
  end

  // A pending error response blocks capture for one cycle: the granted
  // requester may still hold req in the cycle its gnt is visible.
  assign w_capture = (r_state == ARB_IDLE) && !r_err_pend && (if_req_i || dm_req_i);
  assign w_cap_err = is_misaligned(w_cap_size, w_cap_addr[1:0]);
  assign w_resp    = (r_state == ARB_RESP) && mem_rvalid_i;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ARB_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and memory request; stray gnt/rvalid are ignored by state
  always_comb begin
    w_state_nxt = r_state;
    mem_req_o   = 1'b0;
    case (r_state)
      ARB_IDLE: if (w_capture && !w_cap_err) w_state_nxt = ARB_REQ;
      ARB_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) w_state_nxt = ARB_RESP;
      end
      ARB_RESP: if (mem_rvalid_i) w_state_nxt = ARB_IDLE;
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Capture owner, payload and grant pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner    <= OWN_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_size     <= BYTE_ACCESS;
      r_wdata    <= '0;
      r_if_gnt   <= 1'b0;
      r_dm_gnt   <= 1'b0;
      r_err_pend <= 1'b0;
    end else begin
      r_if_gnt   <= w_capture && (w_pick == OWN_IF);
      r_dm_gnt   <= w_capture && (w_pick == OWN_DM);
      r_err_pend <= w_capture && w_cap_err;
      if (w_capture) begin
        r_owner <= w_pick;
        r_we    <= w_cap_we;
        r_addr  <= w_cap_addr;
        r_size  <= w_cap_size;
        r_wdata <= w_cap_wdata;
      end
    end
  end

  // Route local error or memory response to the owner; rdata held between
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_dm_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_dm_err    <= 1'b0;
      if (r_err_pend || w_resp) begin
        if (r_owner == OWN_IF) begin
          r_if_rvalid <= 1'b1;
          r_if_err    <= r_err_pend;
          r_if_rdata  <= r_err_pend ? '0 : mem_rdata_i;
        end else begin
          r_dm_rvalid <= 1'b1;
          r_dm_err    <= r_err_pend;
          r_dm_rdata  <= (r_err_pend || r_we) ? '0 : mem_rdata_i;
        end
      end
    end
  end

  assign if_gnt_o    = r_if_gnt;
  assign if_rvalid_o = r_if_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign if_err_o    = r_if_err;
  assign dm_gnt_o    = r_dm_gnt;
  assign dm_rvalid_o = r_dm_rvalid;
  assign dm_rdata_o  = r_dm_rdata;
  assign dm_err_o    = r_dm_err;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_size_o  = r_size;
  assign mem_wdata_o = r_wdata;

endmodule
